// File: rtl/feeder_sequencer.sv
// Sequencer for the row/column feeders of an N x N output-stationary MAC array.
// Runs one tile per start: load, staggered per-lane shift/valid, drain, done pulse.
module feeder_sequencer #(
    parameter int N = 7,
    parameter int K = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         load,
    output logic         acc_clr,
    output logic [N-1:0] shift,
    output logic [N-1:0] lane_valid,
    output logic         mac_en,
    output logic         busy,
    output logic         done
);

    localparam int RUN_LEN = K + 2 * N - 2;
    localparam int CW      = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RUN_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt only advances in RUN and falls back to 0 everywhere else.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) state_d = ST_DONE;
                else                   cnt_d   = cnt_q + CW'(1);
            end
            ST_DONE: begin
                state_d = start ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_run  = (state_q == ST_RUN);
    assign load    = (state_q == ST_LOAD);
    assign acc_clr = (state_q == ST_LOAD);
    assign mac_en  = in_run;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);

    // Lane gi is live for K cycles from cnt == gi; the extra offset bit makes
    // cnt < gi wrap to a large value so a single compare covers both bounds.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        localparam logic [CW:0] LANE_START = (CW + 1)'(gi);
        localparam logic [CW:0] LANE_LEN   = (CW + 1)'(K);
        logic [CW:0] offset;

        assign offset         = {1'b0, cnt_q} - LANE_START;
        assign lane_valid[gi] = in_run && (offset < LANE_LEN);
        assign shift[gi]      = lane_valid[gi];
    end

endmodule

// File: tb/tb_feeder_sequencer.sv
// Randomized + directed bench for feeder_sequencer (N=7/K=7 and N=2/K=3 instances)
// against a tile-phase reference model.
module tb_feeder_sequencer;

    localparam int N7 = 7, K7 = 7, N2 = 2, K2 = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start7, start2;
    logic          load7, acc_clr7, mac_en7, busy7, done7;
    logic [N7-1:0] shift7, lane_valid7;
    logic          load2, acc_clr2, mac_en2, busy2, done2;
    logic [N2-1:0] shift2, lane_valid2;

    int checks = 0;
    int errors = 0;
    int t7 = 0, t2 = 0;   // cycles since tile began (0 = no tile)
    int cyc = 0;
    int sh_cnt[N7];
    int lv_cnt[N7];
    int mac_cnt, busy_cnt, done_cnt;
    int load_q[$];

    feeder_sequencer #(.N(N7), .K(K7)) dut7 (
        .clk(clk), .reset(reset), .start(start7),
        .load(load7), .acc_clr(acc_clr7), .shift(shift7), .lane_valid(lane_valid7),
        .mac_en(mac_en7), .busy(busy7), .done(done7)
    );

    feeder_sequencer #(.N(N2), .K(K2)) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .load(load2), .acc_clr(acc_clr2), .shift(shift2), .lane_valid(lane_valid2),
        .mac_en(mac_en2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Packed view: {load, acc_clr, busy, done, mac_en, shift[n-1:0], lane_valid[n-1:0]}
    function automatic logic [31:0] expv(input int n, input int k, input int t);
        logic [31:0] v;
        int c, last;
        v    = '0;
        c    = t - 2;
        last = k + 2 * n;
        if (t == 1) begin
            v = v | (32'(1) << (2 * n + 4)) | (32'(1) << (2 * n + 3)) | (32'(1) << (2 * n + 2));
        end else if (t >= 2 && t <= last - 1) begin
            v = v | (32'(1) << (2 * n + 2)) | (32'(1) << (2 * n));
            for (int i = 0; i < n; i++)
                if (c >= i && c <= i + k - 1)
                    v = v | (32'(1) << i) | (32'(1) << (n + i));
        end else if (t == last) begin
            v = v | (32'(1) << (2 * n + 2)) | (32'(1) << (2 * n + 1));
        end
        return v;
    endfunction

    function automatic int next_t(input int n, input int k, input int t, input logic s);
        if (t == 0 || t == k + 2 * n) return s ? 1 : 0;
        return t + 1;
    endfunction

    task automatic clear_stats();
        for (int i = 0; i < N7; i++) begin
            sh_cnt[i] = 0;
            lv_cnt[i] = 0;
        end
        mac_cnt  = 0;
        busy_cnt = 0;
        done_cnt = 0;
        load_q.delete();
        cyc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) begin
            t7 = 0;
            t2 = 0;
        end else begin
            t7 = next_t(N7, K7, t7, start7);
            t2 = next_t(N2, K2, t2, start2);
        end
        cyc++;
        #1;
        check("outs7", 32'({load7, acc_clr7, busy7, done7, mac_en7, shift7, lane_valid7}),
              expv(N7, K7, t7));
        check("outs2", 32'({load2, acc_clr2, busy2, done2, mac_en2, shift2, lane_valid2}),
              expv(N2, K2, t2));
        for (int i = 0; i < N7; i++) begin
            if (shift7[i])      sh_cnt[i]++;
            if (lane_valid7[i]) lv_cnt[i]++;
        end
        if (mac_en7) mac_cnt++;
        if (busy7)   busy_cnt++;
        if (done7)   done_cnt++;
        if (load7)   load_q.push_back(cyc);
    endtask

    task automatic mid_reset();
        start7 = 1'b0;
        start2 = 1'b0;
        reset  = 1'b1;
        #1;
        t7 = 0;
        t2 = 0;
        check("rst_async7", 32'({load7, acc_clr7, busy7, done7, mac_en7, shift7, lane_valid7}), 0);
        check("rst_async2", 32'({load2, acc_clr2, busy2, done2, mac_en2, shift2, lane_valid2}), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int d7, d2;
        reset  = 1'b1;
        start7 = 1'b0;
        start2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset7", 32'({load7, acc_clr7, busy7, done7, mac_en7, shift7, lane_valid7}), 0);
        check("reset2", 32'({load2, acc_clr2, busy2, done2, mac_en2, shift2, lane_valid2}), 0);
        reset = 1'b0;

        // Single tile on both instances: latency and per-lane high counts.
        clear_stats();
        d7 = -1;
        d2 = -1;
        start7 = 1'b1;
        start2 = 1'b1;
        step();
        start7 = 1'b0;
        start2 = 1'b0;
        check("load_cycle", 32'(load_q.size()), 1);
        for (int s = 0; s < 40; s++) begin
            step();
            if (done7 && d7 < 0) d7 = cyc;
            if (done2 && d2 < 0) d2 = cyc;
        end
        check("done_lat7", 32'(d7), 21);
        check("done_lat2", 32'(d2), 7);
        for (int i = 0; i < N7; i++) begin
            check($sformatf("shift_cnt%0d", i), 32'(sh_cnt[i]), K7);
            check($sformatf("valid_cnt%0d", i), 32'(lv_cnt[i]), K7);
        end
        check("mac_cnt", 32'(mac_cnt), 19);
        check("busy_cnt", 32'(busy_cnt), 21);
        check("done_cnt", 32'(done_cnt), 1);

        // start held high: back-to-back tiles every K+2N cycles.
        clear_stats();
        start7 = 1'b1;
        repeat (70) step();
        start7 = 1'b0;
        repeat (30) step();
        check("held_loads", 32'(load_q.size()), 4);
        for (int i = 1; i < load_q.size(); i++)
            check("load_period", 32'(load_q[i] - load_q[i-1]), 21);
        check("held_dones", 32'(done_cnt), 4);

        // start pulsed at RUN cnt=5 is ignored.
        clear_stats();
        start7 = 1'b1;
        step();
        start7 = 1'b0;
        while (cyc < 7) step();
        start7 = 1'b1;
        step();
        start7 = 1'b0;
        repeat (30) step();
        check("ign_done", 32'(done_cnt), 1);
        check("ign_loads", 32'(load_q.size()), 1);
        check("ign_idle", 32'(busy7), 0);

        // Reset at RUN cnt=8, then a fresh tile runs normally.
        clear_stats();
        start7 = 1'b1;
        step();
        start7 = 1'b0;
        while (cyc < 10) step();
        mid_reset();
        repeat (25) step();
        check("rst_no_done", 32'(done_cnt), 0);
        clear_stats();
        d7 = -1;
        start7 = 1'b1;
        step();
        start7 = 1'b0;
        for (int s = 0; s < 30; s++) begin
            step();
            if (done7 && d7 < 0) d7 = cyc;
        end
        check("post_rst_lat", 32'(d7), 21);

        // Random start traffic with occasional asynchronous resets.
        for (int s = 0; s < 2000; s++) begin
            start7 = ($urandom_range(0, 3) == 0);
            start2 = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) mid_reset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
